csr_access_ctrl: RTL and testbench

CSR_ACCESS_CTRL -- requirements
Module: csr_access_ctrl

---
 rtl/csr_access_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 tb/tb_csr_access_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_access_ctrl.sv
// CSR access controller: sequences CSR read-modify-write instructions, ECALL,
// EBREAK and MRET against an external CSR file with a combinational read port.
// All outputs are registered; each is decoded from the state being entered so
// it is valid for exactly the cycle the FSM spends in that state.
`timescale 1ns/1ps
module csr_access_ctrl #(
   parameter logic [11:0] MTVEC_ADDR = 12'h305,
   parameter logic [11:0] MEPC_ADDR  = 12'h341
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [2:0]  funct3,
   input  logic [11:0] csr_addr,
   input  logic [4:0]  src_idx,
   input  logic [31:0] rs1_val,
   input  logic [4:0]  rd_idx,
   input  logic [31:0] pc,
   input  logic [31:0] instr,
   output logic [11:0] csr_addrr,
   input  logic [31:0] csr_rdata,
   output logic [11:0] csr_addrw,
   output logic [31:0] csr_wdata,
   output logic        csr_we,
   output logic        trap_taken,
   output logic [31:0] trap_vector,
   output logic [31:0] trap_pc,
   output logic [31:0] trap_cause,
   output logic [31:0] trap_tval,
   output logic        done,
   output logic        rd_we,
   output logic [4:0]  rd_addr,
   output logic [31:0] rd_wdata,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_READ    = 3'd1,
      S_WRITE   = 3'd2,
      S_TRAP_RD = 3'd3,
      S_TRAP    = 3'd4,
      S_MRET_RD = 3'd5,
      S_MRET    = 3'd6
   } state_t;

   localparam logic [1:0] OP_CSR    = 2'b00;
   localparam logic [1:0] OP_ECALL  = 2'b01;
   localparam logic [1:0] OP_EBREAK = 2'b10;
   localparam logic [1:0] OP_MRET   = 2'b11;

   // CSRRW/CSRRWI always write; set/clear forms only write with a non-zero source.
   function automatic logic wr_enable(input logic [2:0] f3, input logic [4:0] src);
      logic en;
      if (f3[1:0] == 2'b01) begin
         en = 1'b1;
      end else begin
         en = (src != 5'd0);
      end
      return en;
   endfunction

   // Immediate forms use the 5-bit zimm zero-extended, register forms use rs1.
   function automatic logic [31:0] operand(input logic [2:0] f3, input logic [4:0] src,
                                           input logic [31:0] rs1);
      logic [31:0] opnd;
      if (f3[2]) begin
         opnd = {27'd0, src};
      end else begin
         opnd = rs1;
      end
      return opnd;
   endfunction

   // New CSR value for RW / RS / RC given the old value and the operand.
   function automatic logic [31:0] merge(input logic [2:0] f3, input logic [31:0] old,
                                         input logic [31:0] opnd);
      logic [31:0] res;
      case (f3[1:0])
         2'b01:   res = opnd;
         2'b10:   res = old | opnd;
         2'b11:   res = old & ~opnd;
         default: res = opnd;
      endcase
      return res;
   endfunction

   state_t      state_q, state_d;

   logic [1:0]  op_q, op_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [11:0] addr_q, addr_d;
   logic [4:0]  src_q, src_d;
   logic [31:0] rs1_q, rs1_d;
   logic [4:0]  rd_q, rd_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;

   logic        req_ready_q, req_ready_d;
   logic [11:0] csr_addrr_q, csr_addrr_d;
   logic [11:0] csr_addrw_q, csr_addrw_d;
   logic [31:0] csr_wdata_q, csr_wdata_d;
   logic        csr_we_q, csr_we_d;
   logic        trap_taken_q, trap_taken_d;
   logic [31:0] trap_vector_q, trap_vector_d;
   logic [31:0] trap_pc_q, trap_pc_d;
   logic [31:0] trap_cause_q, trap_cause_d;
   logic [31:0] trap_tval_q, trap_tval_d;
   logic        done_q, done_d;
   logic        rd_we_q, rd_we_d;
   logic [4:0]  rd_addr_q, rd_addr_d;
   logic [31:0] rd_wdata_q, rd_wdata_d;
   logic        redirect_valid_q, redirect_valid_d;
   logic [31:0] redirect_pc_q, redirect_pc_d;

   logic        wen_s;
   logic [31:0] target_s;

   assign wen_s    = wr_enable(funct3_q, src_q);
   assign target_s = {csr_rdata[31:2], 2'b00};

   // Next state, request capture and the outputs of the state being entered.
   always_comb begin
      state_d          = state_q;
      op_d             = op_q;
      funct3_d         = funct3_q;
      addr_d           = addr_q;
      src_d            = src_q;
      rs1_d            = rs1_q;
      rd_d             = rd_q;
      pc_d             = pc_q;
      instr_d          = instr_q;
      req_ready_d      = 1'b0;
      csr_addrr_d      = 12'd0;
      csr_addrw_d      = 12'd0;
      csr_wdata_d      = 32'd0;
      csr_we_d         = 1'b0;
      trap_taken_d     = 1'b0;
      trap_vector_d    = 32'd0;
      trap_pc_d        = 32'd0;
      trap_cause_d     = 32'd0;
      trap_tval_d      = 32'd0;
      done_d           = 1'b0;
      rd_we_d          = 1'b0;
      rd_addr_d        = 5'd0;
      rd_wdata_d       = 32'd0;
      redirect_valid_d = 1'b0;
      redirect_pc_d    = 32'd0;

      case (state_q)
         S_IDLE: begin
            if (req_valid && req_ready_q) begin
               op_d     = req_op;
               funct3_d = funct3;
               addr_d   = csr_addr;
               src_d    = src_idx;
               rs1_d    = rs1_val;
               rd_d     = rd_idx;
               pc_d     = pc;
               instr_d  = instr;
               case (req_op)
                  OP_CSR: begin
                     if (funct3[1:0] == 2'b00) begin
                        // funct3 000 / 100 are not CSR instructions: illegal
                        state_d     = S_TRAP_RD;
                        csr_addrr_d = MTVEC_ADDR;
                     end else begin
                        state_d     = S_READ;
                        csr_addrr_d = csr_addr;
                     end
                  end
                  OP_ECALL, OP_EBREAK: begin
                     state_d     = S_TRAP_RD;
                     csr_addrr_d = MTVEC_ADDR;
                  end
                  OP_MRET: begin
                     state_d     = S_MRET_RD;
                     csr_addrr_d = MEPC_ADDR;
                  end
                  default: begin
                     state_d     = S_IDLE;
                     req_ready_d = 1'b1;
                  end
               endcase
            end else begin
               req_ready_d = 1'b1;
            end
         end
         S_READ: begin
            if (wen_s && (addr_q[11:10] == 2'b11)) begin
               // write to a read-only CSR: raise illegal instruction
               state_d     = S_TRAP_RD;
               csr_addrr_d = MTVEC_ADDR;
            end else begin
               state_d     = S_WRITE;
               csr_addrw_d = addr_q;
               csr_wdata_d = merge(funct3_q, csr_rdata, operand(funct3_q, src_q, rs1_q));
               csr_we_d    = wen_s;
               done_d      = 1'b1;
               rd_we_d     = (rd_q != 5'd0);
               rd_addr_d   = rd_q;
               rd_wdata_d  = csr_rdata;
            end
         end
         S_TRAP_RD: begin
            state_d          = S_TRAP;
            trap_taken_d     = 1'b1;
            trap_pc_d        = pc_q;
            trap_vector_d    = target_s;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = target_s;
            done_d           = 1'b1;
            case (op_q)
               OP_ECALL: begin
                  trap_cause_d = 32'd11;
                  trap_tval_d  = 32'd0;
               end
               OP_EBREAK: begin
                  trap_cause_d = 32'd3;
                  trap_tval_d  = pc_q;
               end
               default: begin
                  trap_cause_d = 32'd2;
                  trap_tval_d  = instr_q;
               end
            endcase
         end
         S_MRET_RD: begin
            state_d          = S_MRET;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = target_s;
            done_d           = 1'b1;
         end
         S_WRITE, S_TRAP, S_MRET: begin
            state_d     = S_IDLE;
            req_ready_d = 1'b1;
         end
         default: begin
            state_d     = S_IDLE;
            req_ready_d = 1'b1;
         end
      endcase
   end

   // State, latched request and registered outputs; reset returns to idle at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q          <= S_IDLE;
         op_q             <= 2'd0;
         funct3_q         <= 3'd0;
         addr_q           <= 12'd0;
         src_q            <= 5'd0;
         rs1_q            <= 32'd0;
         rd_q             <= 5'd0;
         pc_q             <= 32'd0;
         instr_q          <= 32'd0;
         req_ready_q      <= 1'b1;
         csr_addrr_q      <= 12'd0;
         csr_addrw_q      <= 12'd0;
         csr_wdata_q      <= 32'd0;
         csr_we_q         <= 1'b0;
         trap_taken_q     <= 1'b0;
         trap_vector_q    <= 32'd0;
         trap_pc_q        <= 32'd0;
         trap_cause_q     <= 32'd0;
         trap_tval_q      <= 32'd0;
         done_q           <= 1'b0;
         rd_we_q          <= 1'b0;
         rd_addr_q        <= 5'd0;
         rd_wdata_q       <= 32'd0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= 32'd0;
      end else begin
         state_q          <= state_d;
         op_q             <= op_d;
         funct3_q         <= funct3_d;
         addr_q           <= addr_d;
         src_q            <= src_d;
         rs1_q            <= rs1_d;
         rd_q             <= rd_d;
         pc_q             <= pc_d;
         instr_q          <= instr_d;
         req_ready_q      <= req_ready_d;
         csr_addrr_q      <= csr_addrr_d;
         csr_addrw_q      <= csr_addrw_d;
         csr_wdata_q      <= csr_wdata_d;
         csr_we_q         <= csr_we_d;
         trap_taken_q     <= trap_taken_d;
         trap_vector_q    <= trap_vector_d;
         trap_pc_q        <= trap_pc_d;
         trap_cause_q     <= trap_cause_d;
         trap_tval_q      <= trap_tval_d;
         done_q           <= done_d;
         rd_we_q          <= rd_we_d;
         rd_addr_q        <= rd_addr_d;
         rd_wdata_q       <= rd_wdata_d;
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
      end
   end

   assign req_ready      = req_ready_q;
   assign csr_addrr      = csr_addrr_q;
   assign csr_addrw      = csr_addrw_q;
   assign csr_wdata      = csr_wdata_q;
   assign csr_we         = csr_we_q;
   assign trap_taken     = trap_taken_q;
   assign trap_vector    = trap_vector_q;
   assign trap_pc        = trap_pc_q;
   assign trap_cause     = trap_cause_q;
   assign trap_tval      = trap_tval_q;
   assign done           = done_q;
   assign rd_we          = rd_we_q;
   assign rd_addr        = rd_addr_q;
   assign rd_wdata       = rd_wdata_q;
   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Self-checking bench for csr_access_ctrl: a transaction-level model predicts
// the per-cycle outputs of every request, a compare process checks them each
// cycle, and literal checks pin the key results of the directed vectors.
`timescale 1ns/1ps
module tb_csr_access_ctrl;

   localparam logic [11:0] MTVEC = 12'h305;
   localparam logic [11:0] MEPC  = 12'h341;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  req_op = 2'd0;
   logic [2:0]  funct3 = 3'd0;
   logic [11:0] csr_addr = 12'd0;
   logic [4:0]  src_idx = 5'd0;
   logic [31:0] rs1_val = 32'd0;
   logic [4:0]  rd_idx = 5'd0;
   logic [31:0] pc = 32'd0;
   logic [31:0] instr = 32'd0;
   logic [11:0] csr_addrr;
   logic [31:0] csr_rdata;
   logic [11:0] csr_addrw;
   logic [31:0] csr_wdata;
   logic        csr_we;
   logic        trap_taken;
   logic [31:0] trap_vector, trap_pc, trap_cause, trap_tval;
   logic        done;
   logic        rd_we;
   logic [4:0]  rd_addr;
   logic [31:0] rd_wdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   logic [31:0] csr_file [0:4095];
   assign csr_rdata = csr_file[csr_addrr];

   csr_access_ctrl #(.MTVEC_ADDR(12'h305), .MEPC_ADDR(12'h341)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .funct3(funct3), .csr_addr(csr_addr), .src_idx(src_idx),
      .rs1_val(rs1_val), .rd_idx(rd_idx), .pc(pc), .instr(instr),
      .csr_addrr(csr_addrr), .csr_rdata(csr_rdata), .csr_addrw(csr_addrw),
      .csr_wdata(csr_wdata), .csr_we(csr_we), .trap_taken(trap_taken),
      .trap_vector(trap_vector), .trap_pc(trap_pc), .trap_cause(trap_cause),
      .trap_tval(trap_tval), .done(done), .rd_we(rd_we), .rd_addr(rd_addr),
      .rd_wdata(rd_wdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        ready;
      logic [11:0] addrr;
      logic [11:0] addrw;
      logic [31:0] wdata;
      logic        we;
      logic        tt;
      logic [31:0] tvec, tpc, tcause, ttval;
      logic        done;
      logic        rd_we;
      logic [4:0]  rd_addr;
      logic [31:0] rd_wdata;
      logic        rv;
      logic [31:0] rpc;
   } obs_t;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   done_cnt = 0;
   int   we_cnt = 0;
   int   done_cyc = -1;
   obs_t snap;
   obs_t exp_q[$];

   logic        pend_we;
   logic [11:0] pend_addr;
   logic [31:0] pend_data;

   function automatic obs_t idle_obs();
      obs_t o;
      o.ready = 1'b1; o.addrr = 12'd0; o.addrw = 12'd0; o.wdata = 32'd0; o.we = 1'b0;
      o.tt = 1'b0; o.tvec = 32'd0; o.tpc = 32'd0; o.tcause = 32'd0; o.ttval = 32'd0;
      o.done = 1'b0; o.rd_we = 1'b0; o.rd_addr = 5'd0; o.rd_wdata = 32'd0;
      o.rv = 1'b0; o.rpc = 32'd0;
      return o;
   endfunction

   function automatic obs_t sample();
      obs_t o;
      o.ready = req_ready; o.addrr = csr_addrr; o.addrw = csr_addrw; o.wdata = csr_wdata;
      o.we = csr_we; o.tt = trap_taken; o.tvec = trap_vector; o.tpc = trap_pc;
      o.tcause = trap_cause; o.ttval = trap_tval; o.done = done; o.rd_we = rd_we;
      o.rd_addr = rd_addr; o.rd_wdata = rd_wdata; o.rv = redirect_valid; o.rpc = redirect_pc;
      return o;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cmp_obs(input obs_t a, input obs_t e);
      string c;
      c = $sformatf("cyc%0d", cyc);
      chk({c, " req_ready"}, 32'(a.ready), 32'(e.ready));
      chk({c, " csr_addrr"}, 32'(a.addrr), 32'(e.addrr));
      chk({c, " csr_addrw"}, 32'(a.addrw), 32'(e.addrw));
      chk({c, " csr_wdata"}, a.wdata, e.wdata);
      chk({c, " csr_we"}, 32'(a.we), 32'(e.we));
      chk({c, " trap_taken"}, 32'(a.tt), 32'(e.tt));
      chk({c, " trap_vector"}, a.tvec, e.tvec);
      chk({c, " trap_pc"}, a.tpc, e.tpc);
      chk({c, " trap_cause"}, a.tcause, e.tcause);
      chk({c, " trap_tval"}, a.ttval, e.ttval);
      chk({c, " done"}, 32'(a.done), 32'(e.done));
      chk({c, " rd_we"}, 32'(a.rd_we), 32'(e.rd_we));
      chk({c, " rd_addr"}, 32'(a.rd_addr), 32'(e.rd_addr));
      chk({c, " rd_wdata"}, a.rd_wdata, e.rd_wdata);
      chk({c, " redirect_valid"}, 32'(a.rv), 32'(e.rv));
      chk({c, " redirect_pc"}, a.rpc, e.rpc);
   endtask

   // cycle counter: during cycle N (between posedges) cyc holds N
   always @(posedge clk) cyc <= cyc + 1;

   // compare process: every cycle, DUT outputs against the model's expectation
   always @(negedge clk) begin : compare_p
      obs_t e;
      obs_t a;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = idle_obs();
      a = sample();
      cmp_obs(a, e);
      if (a.done === 1'b1) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc;
         snap = a;
      end
      if (a.we === 1'b1) we_cnt = we_cnt + 1;
   end

   // Transaction model: from the request and the CSR contents, list the CSR
   // addresses read on the way, then the completion cycle's outputs.
   task automatic push_model(input logic [1:0] op, input logic [2:0] f3,
                             input logic [11:0] addr, input logic [4:0] src,
                             input logic [31:0] rs1, input logic [4:0] rd,
                             input logic [31:0] pcv, input logic [31:0] ins);
      obs_t        w, fin;
      logic [11:0] reads[$];
      bit          trap, wen;
      logic [31:0] cause, tval, opnd, old, nval, tgt;
      fin = idle_obs();
      fin.ready = 1'b0;
      fin.done = 1'b1;
      pend_we = 1'b0;
      trap = 1'b0; cause = 32'd0; tval = 32'd0;
      if (op == 2'b00) begin
         if (f3[1:0] == 2'b00) begin
            trap = 1'b1; cause = 32'd2; tval = ins;
         end else begin
            wen  = (f3[1:0] == 2'b01) || (src != 5'd0);
            opnd = f3[2] ? {27'd0, src} : rs1;
            reads.push_back(addr);
            if (wen && addr[11:10] == 2'b11) begin
               trap = 1'b1; cause = 32'd2; tval = ins;
            end else begin
               old = csr_file[addr];
               if (f3[1:0] == 2'b01) nval = opnd;
               else if (f3[1:0] == 2'b10) nval = old | opnd;
               else nval = old & ~opnd;
               fin.addrw = addr; fin.wdata = nval; fin.we = wen;
               fin.rd_we = (rd != 5'd0); fin.rd_addr = rd; fin.rd_wdata = old;
               pend_we = wen; pend_addr = addr; pend_data = nval;
            end
         end
      end else if (op == 2'b01) begin
         trap = 1'b1; cause = 32'd11; tval = 32'd0;
      end else if (op == 2'b10) begin
         trap = 1'b1; cause = 32'd3; tval = pcv;
      end else begin
         reads.push_back(MEPC);
         fin.rv = 1'b1;
         fin.rpc = csr_file[MEPC] & 32'hFFFF_FFFC;
      end
      if (trap) begin
         reads.push_back(MTVEC);
         tgt = csr_file[MTVEC] & 32'hFFFF_FFFC;
         fin.tt = 1'b1; fin.tvec = tgt; fin.rv = 1'b1; fin.rpc = tgt;
         fin.tpc = pcv; fin.tcause = cause; fin.ttval = tval;
      end
      foreach (reads[i]) begin
         w = idle_obs();
         w.ready = 1'b0;
         w.addrr = reads[i];
         exp_q.push_back(w);
      end
      exp_q.push_back(fin);
   endtask

   task automatic scramble();
      req_op = 2'($urandom); funct3 = 3'($urandom); csr_addr = 12'($urandom);
      src_idx = 5'($urandom); rs1_val = $urandom; rd_idx = 5'($urandom);
      pc = $urandom; instr = $urandom;
   endtask

   task automatic run_txn(input string nm, input logic [1:0] op, input logic [2:0] f3,
                          input logic [11:0] addr, input logic [4:0] src,
                          input logic [31:0] rs1, input logic [4:0] rd,
                          input logic [31:0] pcv, input logic [31:0] ins,
                          input int lat_exp);
      int acc, guard;
      @(negedge clk); #1;
      req_op = op; funct3 = f3; csr_addr = addr; src_idx = src; rs1_val = rs1;
      rd_idx = rd; pc = pcv; instr = ins; req_valid = 1'b1;
      acc = cyc;
      done_cyc = -1;
      push_model(op, f3, addr, src, rs1, rd, pcv, ins);
      @(posedge clk); #1;
      req_valid = 1'b0;
      scramble();
      guard = 0;
      while (exp_q.size() != 0 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      chk({nm, " drain"}, 32'(guard < 20), 32'd1);
      @(negedge clk);
      chk({nm, " latency"}, 32'(done_cyc - acc), 32'(lat_exp));
      if (pend_we) csr_file[pend_addr] = pend_data;
      pend_we = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      n_bad++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin : main
      int dc, wc;
      pend_we = 1'b0; pend_addr = 12'd0; pend_data = 32'd0;
      for (int i = 0; i < 4096; i++) csr_file[12'(i)] = 32'd0;
      csr_file[12'h300] = 32'h0000_0008;
      csr_file[12'h304] = 32'h0000_00FF;
      csr_file[MEPC]    = 32'h0000_0104;
      csr_file[12'hC01] = 32'h0000_1234;

      repeat (3) @(negedge clk);
      #1;
      chk("reset req_ready", 32'(req_ready), 32'd1);
      chk("reset done", 32'(done), 32'd0);
      chk("reset csr_addrr", 32'(csr_addrr), 32'd0);
      rst = 1'b0;

      // CSRRW x5, mtvec, rs1=0x80000100, old 0
      run_txn("csrrw", 2'b00, 3'b001, 12'h305, 5'd1, 32'h8000_0100, 5'd5, 32'h10, 32'h3050_92F3, 2);
      chk("csrrw wdata", snap.wdata, 32'h8000_0100);
      chk("csrrw we", 32'(snap.we), 32'd1);
      chk("csrrw rd_we", 32'(snap.rd_we), 32'd1);
      chk("csrrw rd_wdata", snap.rd_wdata, 32'd0);

      // CSRRS x0, mstatus, x0: no write, no rd
      run_txn("csrrs0", 2'b00, 3'b010, 12'h300, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'h14, 32'h3000_2073, 2);
      chk("csrrs0 we", 32'(snap.we), 32'd0);
      chk("csrrs0 rd_we", 32'(snap.rd_we), 32'd0);

      // CSRRCI x3, mie, zimm=5, old 0xFF
      run_txn("csrrci", 2'b00, 3'b111, 12'h304, 5'd5, 32'hDEAD_BEEF, 5'd3, 32'h18, 32'h3042_F1F3, 2);
      chk("csrrci wdata", snap.wdata, 32'h0000_00FA);
      chk("csrrci rd_wdata", snap.rd_wdata, 32'h0000_00FF);

      // CSRRWI x1, 0xC00, zimm=1: read-only write, trap one cycle later
      run_txn("ro_trap", 2'b00, 3'b101, 12'hC00, 5'd1, 32'd0, 5'd1, 32'h1C, 32'hC000_D0F3, 3);
      chk("ro_trap taken", 32'(snap.tt), 32'd1);
      chk("ro_trap cause", snap.tcause, 32'd2);
      chk("ro_trap tval", snap.ttval, 32'hC000_D0F3);
      chk("ro_trap we", 32'(snap.we), 32'd0);

      // ECALL at 0x100 with mtvec 0x201
      csr_file[MTVEC] = 32'h0000_0201;
      run_txn("ecall", 2'b01, 3'b000, 12'h000, 5'd0, 32'd0, 5'd0, 32'h100, 32'h0000_0073, 2);
      chk("ecall taken", 32'(snap.tt), 32'd1);
      chk("ecall cause", snap.tcause, 32'd11);
      chk("ecall tval", snap.ttval, 32'd0);
      chk("ecall trap_pc", snap.tpc, 32'h100);
      chk("ecall redirect_pc", snap.rpc, 32'h200);

      // EBREAK at 0x2000
      run_txn("ebreak", 2'b10, 3'b000, 12'h000, 5'd0, 32'd0, 5'd0, 32'h2000, 32'h0010_0073, 2);
      chk("ebreak cause", snap.tcause, 32'd3);
      chk("ebreak tval", snap.ttval, 32'h2000);

      // MRET with mepc 0x104
      run_txn("mret", 2'b11, 3'b000, 12'h000, 5'd0, 32'd0, 5'd0, 32'h300, 32'h3020_0073, 2);
      chk("mret redirect_pc", snap.rpc, 32'h104);
      chk("mret trap_taken", 32'(snap.tt), 32'd0);
      chk("mret we", 32'(snap.we), 32'd0);

      // illegal funct3 000 and 100 on the CSR opcode
      run_txn("ill000", 2'b00, 3'b000, 12'h300, 5'd2, 32'd7, 5'd4, 32'h400, 32'h3001_0273, 2);
      chk("ill000 cause", snap.tcause, 32'd2);
      run_txn("ill100", 2'b00, 3'b100, 12'h300, 5'd2, 32'd7, 5'd4, 32'h404, 32'h3001_4273, 2);
      chk("ill100 tval", snap.ttval, 32'h3001_4273);

      // read of a read-only CSR without write is legal
      run_txn("ro_read", 2'b00, 3'b011, 12'hC01, 5'd0, 32'h0000_00F0, 5'd7, 32'h408, 32'hC010_33F3, 2);
      chk("ro_read rd_wdata", snap.rd_wdata, 32'h0000_1234);
      chk("ro_read we", 32'(snap.we), 32'd0);
      run_txn("ro_readi", 2'b00, 3'b110, 12'hC00, 5'd0, 32'd0, 5'd8, 32'h40C, 32'hC000_6473, 2);

      // CSRRS with a nonzero source register
      run_txn("csrrs", 2'b00, 3'b010, 12'h300, 5'd9, 32'h0000_0030, 5'd10, 32'h410, 32'h3004_A573, 2);
      chk("csrrs wdata", snap.wdata, 32'h0000_0038);

      // reset asserted while the FSM is reading
      @(negedge clk); #1;
      req_op = 2'b00; funct3 = 3'b001; csr_addr = 12'h300; src_idx = 5'd2;
      rs1_val = 32'h0000_DEAD; rd_idx = 5'd6; pc = 32'h500; instr = 32'h3001_1373;
      req_valid = 1'b1;
      push_model(req_op, funct3, csr_addr, src_idx, rs1_val, rd_idx, pc, instr);
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk); #1;
      dc = done_cnt;
      wc = we_cnt;
      rst = 1'b1;
      exp_q.delete();
      pend_we = 1'b0;
      #1;
      chk("rst_mid req_ready", 32'(req_ready), 32'd1);
      chk("rst_mid csr_addrr", 32'(csr_addrr), 32'd0);
      chk("rst_mid csr_we", 32'(csr_we), 32'd0);
      chk("rst_mid done", 32'(done), 32'd0);
      repeat (2) @(negedge clk);
      #1;
      rst = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      chk("rst_mid no done after", 32'(done_cnt), 32'(dc));
      chk("rst_mid no csr_we after", 32'(we_cnt), 32'(wc));

      // recovery after reset
      run_txn("recover", 2'b00, 3'b001, 12'h340, 5'd3, 32'h1234_5678, 5'd11, 32'h600, 32'h3401_95F3, 2);
      chk("recover wdata", snap.wdata, 32'h1234_5678);

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
